// File: rtl/alu_issue_stage_if.sv
// Signal bundle between the decoder, the issue stage, the ALU and the EX/MEM consumer.
// The slave view belongs to the issue stage. The master view belongs to its environment.
interface alu_issue_stage_if #(
  parameter int WIDTH    = 32,
  parameter int RD_WIDTH = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_alu_op;
  logic [WIDTH-1:0]    in_rs1;
  logic [WIDTH-1:0]    in_rs2;
  logic [WIDTH-1:0]    in_imm;
  logic                in_use_imm;
  logic [RD_WIDTH-1:0] in_rd;
  logic [WIDTH-1:0]    alu_first;
  logic [WIDTH-1:0]    alu_second;
  logic [1:0]          alu_op;
  logic [WIDTH-1:0]    alu_result;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_result;
  logic                out_zero;
  logic [RD_WIDTH-1:0] out_rd;
  logic                out_illegal;

  modport slave (
    input  in_valid, in_alu_op, in_rs1, in_rs2, in_imm, in_use_imm, in_rd,
           alu_result, out_ready,
    output in_ready, alu_first, alu_second, alu_op,
           out_valid, out_result, out_zero, out_rd, out_illegal
  );

  modport master (
    output in_valid, in_alu_op, in_rs1, in_rs2, in_imm, in_use_imm, in_rd,
           alu_result, out_ready,
    input  in_ready, alu_first, alu_second, alu_op,
           out_valid, out_result, out_zero, out_rd, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Execute-stage front end. It registers the conditioned ALU operands and holds them for the op latency.
// It then captures the ALU result for EX/MEM. At most one op is in flight at a time.
module alu_issue_stage #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 8,
  parameter int RD_WIDTH    = 5
) (
  input  logic               clk,
  input  logic               reset,
  alu_issue_stage_if.slave   bus
);
  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_MUL     = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  logic [1:0]          state;
  logic [CNT_W-1:0]    count;
  logic [RD_WIDTH-1:0] pend_rd;
  logic                in_ready_int;
  logic                accept;
  logic [WIDTH-1:0]    operand_b;
  logic [WIDTH-1:0]    second_next;
  logic [CNT_W-1:0]    count_init;

  // A waiting result frees the stage for a new op only in the cycle it is consumed.
  assign in_ready_int  = (state == ST_IDLE) || ((state == ST_HOLD) && bus.out_ready);
  assign accept        = bus.in_valid && in_ready_int;
  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = (state == ST_HOLD);

  // The ALU can only add, so subtraction is issued as an add of the negated operand.
  assign operand_b   = bus.in_use_imm ? bus.in_imm : bus.in_rs2;
  assign second_next = (bus.in_alu_op == OP_SUB) ? (~operand_b + WIDTH'(1)) : operand_b;
  assign count_init  = (bus.in_alu_op == OP_MUL) ? CNT_W'(MUL_LATENCY - 1) : '0;

  // NOTE: state registers take non-blocking assignments, so every read in this block sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      count           <= '0;
      pend_rd         <= '0;
      bus.alu_first   <= '0;
      bus.alu_second  <= '0;
      bus.alu_op      <= '0;
      bus.out_result  <= '0;
      bus.out_zero    <= 1'b0;
      bus.out_rd      <= '0;
      bus.out_illegal <= 1'b0;
    end else begin
      case (state)
        ST_EXEC: begin
          if (count == '0) begin
            bus.out_result  <= bus.alu_result;
            bus.out_zero    <= (bus.alu_result == '0);
            bus.out_rd      <= pend_rd;
            bus.out_illegal <= 1'b0;
            state           <= ST_HOLD;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            bus.alu_first  <= bus.in_rs1;
            bus.alu_second <= second_next;
            bus.alu_op     <= bus.in_alu_op;
            pend_rd        <= bus.in_rd;
            count          <= count_init;
            // An illegal op never occupies the ALU and completes on the next edge with a zero result.
            if (bus.in_alu_op == OP_ILLEGAL) begin
              bus.out_result  <= '0;
              bus.out_zero    <= 1'b1;
              bus.out_rd      <= bus.in_rd;
              bus.out_illegal <= 1'b1;
              state           <= ST_HOLD;
            end else begin
              state <= ST_EXEC;
            end
          end else if ((state == ST_HOLD) && bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage. A transaction-level model predicts every output on every cycle.
// Directed vectors carry hand-computed literal expectations that pin the model.
module tb_alu_issue_stage;
  localparam int W  = 32;
  localparam int ML = 8;
  localparam int RW = 5;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] ILL = 2'b11;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_issue_stage_if #(.WIDTH(W), .RD_WIDTH(RW)) bus ();

  alu_issue_stage #(.WIDTH(W), .MUL_LATENCY(ML), .RD_WIDTH(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // External ALU: it adds, or it multiplies and keeps the low bits.
  assign bus.alu_result = (bus.alu_op == MUL) ? bus.alu_first * bus.alu_second
                                              : bus.alu_first + bus.alu_second;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] f_result(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      MUL:     return a * b;
      default: return '0;
    endcase
  endfunction

  // Transaction model: one op in flight, remaining cycles until its result appears.
  int            m_remain;
  logic          m_valid;
  logic [W-1:0]  m_result;
  logic [W-1:0]  m_pend_result;
  logic [RW-1:0] m_rd;
  logic [RW-1:0] m_pend_rd;
  logic          m_illegal;
  logic [W-1:0]  m_first;
  logic [W-1:0]  m_second;
  logic [1:0]    m_op;
  logic          m_in_ready;
  logic [W-1:0]  m_b;

  assign m_in_ready = (m_remain == 0) && (!m_valid || bus.out_ready);
  assign m_b        = bus.in_use_imm ? bus.in_imm : bus.in_rs2;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_remain      <= 0;
      m_valid       <= 1'b0;
      m_result      <= '0;
      m_pend_result <= '0;
      m_rd          <= '0;
      m_pend_rd     <= '0;
      m_illegal     <= 1'b0;
      m_first       <= '0;
      m_second      <= '0;
      m_op          <= '0;
    end else if (bus.in_valid && m_in_ready) begin
      m_first  <= bus.in_rs1;
      m_second <= (bus.in_alu_op == SUB) ? -m_b : m_b;
      m_op     <= bus.in_alu_op;
      if (bus.in_alu_op == ILL) begin
        m_valid   <= 1'b1;
        m_result  <= '0;
        m_illegal <= 1'b1;
        m_rd      <= bus.in_rd;
        m_remain  <= 0;
      end else begin
        m_valid       <= 1'b0;
        m_remain      <= (bus.in_alu_op == MUL) ? ML : 1;
        m_pend_result <= f_result(bus.in_alu_op, bus.in_rs1, m_b);
        m_pend_rd     <= bus.in_rd;
      end
    end else if (m_remain > 0) begin
      m_remain <= m_remain - 1;
      if (m_remain == 1) begin
        m_valid   <= 1'b1;
        m_result  <= m_pend_result;
        m_illegal <= 1'b0;
        m_rd      <= m_pend_rd;
      end
    end else if (m_valid && bus.out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("in_ready", 64'(bus.in_ready), 64'(m_in_ready));
      check("out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("alu_first", 64'(bus.alu_first), 64'(m_first));
      check("alu_second", 64'(bus.alu_second), 64'(m_second));
      check("alu_op", 64'(bus.alu_op), 64'(m_op));
      if (m_valid) begin
        check("out_result", 64'(bus.out_result), 64'(m_result));
        check("out_zero", 64'(bus.out_zero), 64'(m_result == '0));
        check("out_rd", 64'(bus.out_rd), 64'(m_rd));
        check("out_illegal", 64'(bus.out_illegal), 64'(m_illegal));
      end
    end
  end

  // Call this one time unit after a rising edge. It returns the same way, after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] rs1, input logic [W-1:0] rs2,
                       input logic [W-1:0] imm, input logic use_imm, input logic [RW-1:0] rd,
                       output int waits);
    logic hs;
    hs    = 1'b0;
    waits = 0;
    bus.in_valid   = 1'b1;
    bus.in_alu_op  = op;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_imm     = imm;
    bus.in_use_imm = use_imm;
    bus.in_rd      = rd;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk);
      #1;
      if (hs) break;
      waits++;
    end
    bus.in_valid = 1'b0;
    check("issue_accept", 64'(hs), 64'(1));
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  rs1;
    logic [W-1:0]  rs2;
    logic [W-1:0]  imm;
    logic          use_imm;
    logic [RW-1:0] rd;
  } vec_t;

  vec_t vecs[6];
  int   w;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.in_valid = 1'b0; bus.in_alu_op = ADD; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_imm = '0; bus.in_use_imm = 1'b0; bus.in_rd = '0; bus.out_ready = 1'b1;

    #7;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_alu_second", 64'(bus.alu_second), 64'(0));
    check("rst_out_result", 64'(bus.out_result), 64'(0));
    #5 reset = 1'b0;
    @(posedge clk); #1;

    // add 5 + 7: result one cycle after accept
    issue(ADD, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, w);
    @(negedge clk);
    check("add_exec_valid", 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    check("add_valid", 64'(bus.out_valid), 64'(1));
    check("add_result", 64'(bus.out_result), 64'(12));
    check("add_zero", 64'(bus.out_zero), 64'(0));
    check("add_rd", 64'(bus.out_rd), 64'(3));
    @(posedge clk); #1;

    // sub 3 - imm 3
    issue(SUB, 32'd3, 32'd99, 32'd3, 1'b1, 5'd4, w);
    @(negedge clk);
    check("sub_second", 64'(bus.alu_second), 64'(32'hFFFF_FFFD));
    @(negedge clk);
    check("sub_result", 64'(bus.out_result), 64'(0));
    check("sub_zero", 64'(bus.out_zero), 64'(1));
    @(posedge clk); #1;

    // mul wraps to zero, eight EXEC cycles with in_ready low
    issue(MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 5'd7, w);
    for (int i = 0; i < ML; i++) begin
      @(negedge clk);
      check("mul_busy_ready", 64'(bus.in_ready), 64'(0));
      check("mul_busy_valid", 64'(bus.out_valid), 64'(0));
    end
    @(negedge clk);
    check("mul_valid", 64'(bus.out_valid), 64'(1));
    check("mul_result", 64'(bus.out_result), 64'(0));
    check("mul_zero", 64'(bus.out_zero), 64'(1));
    @(posedge clk); #1;

    // back-pressure: result held, then consumed in the same cycle a new op is accepted
    bus.out_ready = 1'b0;
    issue(ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd4, w);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(bus.out_valid), 64'(1));
      check("bp_result", 64'(bus.out_result), 64'(2));
      check("bp_ready", 64'(bus.in_ready), 64'(0));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    issue(ADD, 32'd10, 32'd20, 32'd0, 1'b0, 5'd5, w);
    check("bp_same_cycle", 64'(w), 64'(0));
    @(negedge clk);
    @(negedge clk);
    check("bp_new_result", 64'(bus.out_result), 64'(30));
    @(posedge clk); #1;

    // illegal op
    issue(ILL, 32'd8, 32'd8, 32'd0, 1'b0, 5'd9, w);
    @(negedge clk);
    check("ill_valid", 64'(bus.out_valid), 64'(1));
    check("ill_flag", 64'(bus.out_illegal), 64'(1));
    check("ill_result", 64'(bus.out_result), 64'(0));
    check("ill_rd", 64'(bus.out_rd), 64'(9));
    @(posedge clk); #1;

    // back-to-back ops with out_ready high
    vecs[0] = '{ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd1};
    vecs[1] = '{SUB, 32'd0, 32'd1, 32'd0, 1'b0, 5'd2};
    vecs[2] = '{MUL, 32'd7, 32'd0, 32'hFFFF_FFFD, 1'b1, 5'd3};
    vecs[3] = '{ADD, 32'h1234_5678, 32'd0, 32'h0000_1000, 1'b1, 5'd31};
    vecs[4] = '{ILL, 32'd1, 32'd2, 32'd3, 1'b0, 5'd17};
    vecs[5] = '{SUB, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 1'b0, 5'd6};
    for (int i = 0; i < 6; i++)
      issue(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].use_imm, vecs[i].rd, w);
    repeat (ML + 2) @(posedge clk);
    #1;

    // reset three cycles into a mul
    issue(MUL, 32'd3, 32'd4, 32'd0, 1'b0, 5'd12, w);
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("rr_out_valid", 64'(bus.out_valid), 64'(0));
    check("rr_alu_first", 64'(bus.alu_first), 64'(0));
    check("rr_alu_op", 64'(bus.alu_op), 64'(0));
    check("rr_out_rd", 64'(bus.out_rd), 64'(0));
    #10 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("rr_no_valid", 64'(bus.out_valid), 64'(0));
    end
    @(posedge clk); #1;
    issue(ADD, 32'd40, 32'd2, 32'd0, 1'b0, 5'd8, w);
    @(negedge clk); @(negedge clk);
    check("rr_recover", 64'(bus.out_result), 64'(42));
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
